// File: rtl/powerof3_pkg.sv
// powerof3_pkg: shared widths, in-flight tag type and pointer helper for the scheduler
package powerof3_pkg;
    localparam int NUM_W = 32;
    localparam int MAX_NREQ = 16;
    localparam int ID_W = $clog2(MAX_NREQ);
    typedef struct packed {
        logic valid;
        logic [ID_W-1:0] id;
        logic [NUM_W-1:0] num;
    } p3_tag_t;
    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id, input int n);
        return (int'(id) + 1 >= n) ? '0 : id + 1'b1;
    endfunction
endpackage

// File: rtl/powerof3.sv
// powerof3: registered check whether a 32-bit number is an integer power of three
module powerof3 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] num,
    output logic        ispow3
);
    // 3^20 is the largest 32-bit power of three and, being a prime power, only powers of three divide it
    always_ff @(posedge clk or posedge rst)
        if (rst) ispow3 <= 1'b0;
        else ispow3 <= (num != 32'd0) && (32'd3486784401 % num == 32'd0);
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting the scan at ptr
module rr_arbiter #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_id
);
    logic found;
    int idx;
    // first requester at or after ptr, wrapping modulo N
    always_comb begin
        gnt = '0;
        gnt_id = '0;
        found = 1'b0;
        idx = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id = W'(idx);
            end
        end
    end
endmodule

// File: rtl/powerof3_sched.sv
// powerof3_sched: round-robin sharing of one powerof3 checker with tagged, counted responses
module powerof3_sched
    import powerof3_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT = 2,
    parameter int CNTW = 16,
    localparam int IW = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*NUM_W-1:0]  req_num,
    output logic [NREQ-1:0]        req_ready,
    output logic [NUM_W-1:0]       chk_num,
    input  logic                   chk_ispow3,
    output logic                   resp_valid,
    output logic [IW-1:0]          resp_id,
    output logic [NUM_W-1:0]       resp_num,
    output logic                   resp_ispow3,
    input  logic                   clr_counts,
    output logic [NREQ*CNTW-1:0]   hit_count
);
    logic [IW-1:0] ptr;
    logic [IW-1:0] gnt_id;
    logic acc;
    logic [NUM_W-1:0] acc_num;
    p3_tag_t new_tag;
    p3_tag_t last;
    p3_tag_t tags [LAT];
    logic [CNTW-1:0] cnt [NREQ];

    rr_arbiter #(.N(NREQ)) u_arb (
        .req(req_valid),
        .ptr(ptr),
        .gnt(req_ready),
        .gnt_id(gnt_id)
    );

    // any valid request is granted, so an accept happens whenever one is present
    assign acc = |req_valid;
    assign acc_num = req_num[gnt_id*NUM_W +: NUM_W];
    assign new_tag = acc ? {1'b1, ID_W'(gnt_id), acc_num} : '0;
    assign last = tags[LAT-1];

    // priority pointer and checker operand advance only on an accept
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ptr <= '0;
            chk_num <= '0;
        end else if (acc) begin
            ptr <= IW'(next_ptr(ID_W'(gnt_id), NREQ));
            chk_num <= acc_num;
        end

    // tag shift register tracks each operand through the fixed checker latency
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < LAT; i++) tags[i] <= '0;
        end else begin
            tags[0] <= new_tag;
            for (int i = 1; i < LAT; i++) tags[i] <= tags[i-1];
        end

    // response registers pair the emerging tag with the checker result
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            resp_valid <= 1'b0;
            resp_id <= '0;
            resp_num <= '0;
            resp_ispow3 <= 1'b0;
        end else begin
            resp_valid <= last.valid;
            if (last.valid) begin
                resp_id <= IW'(last.id);
                resp_num <= last.num;
                resp_ispow3 <= chk_ispow3;
            end
        end

    // per-requester saturating hit counters, clear taking precedence
    always_ff @(posedge clk or posedge rst)
        if (rst || clr_counts) begin
            for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
        end else if (resp_valid && resp_ispow3 && cnt[resp_id] != '1) begin
            cnt[resp_id] <= cnt[resp_id] + 1'b1;
        end

    for (genvar g = 0; g < NREQ; g++) begin : g_hit
        assign hit_count[CNTW*g +: CNTW] = cnt[g];
    end
endmodule

// File: tb/tb_powerof3_sched.sv
// tb_powerof3_sched: scoreboard bench for the shared powerof3 scheduler
module tb_powerof3_sched;
    localparam int NREQ = 4;
    localparam int LAT = 2;

    typedef struct {
        int due;
        int id;
        logic [31:0] num;
        logic pow3;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr_counts = 1'b0;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ*32-1:0] req_num = '0;
    logic [NREQ-1:0] req_ready, rdy_b;
    logic [31:0] chk_num, chk_num_b, resp_num, rnum_b;
    logic chk_ispow3, chk_b, resp_valid, rv_b, resp_ispow3, rp3_b;
    logic [1:0] resp_id, rid_b;
    logic [NREQ*16-1:0] hit_count;
    logic [NREQ*2-1:0] hit_b;

    logic [31:0] pend [NREQ][$];
    exp_t sb[$];
    logic [NREQ-1:0] acc;
    int checks = 0, passed = 0, fails = 0, cyc = 0;

    powerof3_sched #(.NREQ(NREQ), .LAT(LAT), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_num(req_num), .req_ready(req_ready),
        .chk_num(chk_num), .chk_ispow3(chk_ispow3), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_num(resp_num), .resp_ispow3(resp_ispow3), .clr_counts(clr_counts), .hit_count(hit_count)
    );
    powerof3 u_chk (.clk(clk), .rst(rst), .num(chk_num), .ispow3(chk_ispow3));

    powerof3_sched #(.NREQ(NREQ), .LAT(LAT), .CNTW(2)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_num(req_num), .req_ready(rdy_b),
        .chk_num(chk_num_b), .chk_ispow3(chk_b), .resp_valid(rv_b), .resp_id(rid_b),
        .resp_num(rnum_b), .resp_ispow3(rp3_b), .clr_counts(clr_counts), .hit_count(hit_b)
    );
    powerof3 u_chk_b (.clk(clk), .rst(rst), .num(chk_num_b), .ispow3(chk_b));

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_pow3(input logic [31:0] n);
        logic [63:0] p = 64'd1;
        for (int i = 0; i <= 20; i++) begin
            if (p == {32'd0, n}) return 1'b1;
            p = p * 3;
        end
        return 1'b0;
    endfunction

    function automatic logic busy();
        logic b = sb.size() != 0;
        for (int i = 0; i < NREQ; i++) if (pend[i].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = pend[i].size() != 0;
            req_num[32*i +: 32] = pend[i].size() != 0 ? pend[i][0] : 32'd0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        acc = rst ? '0 : (req_valid & req_ready);
        @(posedge clk);
        #2;
        for (int i = 0; i < NREQ; i++) if (acc[i]) void'(pend[i].pop_front());
        drive();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (busy() && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_drain_busy"}, 64'(busy()), 64'd0);
        repeat (2) tick();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_resp_id"}, 64'(resp_id), 64'd0);
        chk({tag, "_resp_num"}, 64'(resp_num), 64'd0);
        chk({tag, "_resp_ispow3"}, 64'(resp_ispow3), 64'd0);
        chk({tag, "_chk_num"}, 64'(chk_num), 64'd0);
        chk({tag, "_hit_count"}, hit_count, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_zero("reset");
        tick();
        rst = 1'b0;
    endtask

    // scoreboard monitor: reference arbiter, expected responses and reference hit counts
    initial begin
        int mptr, gid;
        int mcnt [NREQ];
        logic [NREQ-1:0] eg;
        logic ev;
        exp_t e;
        mptr = 0;
        gid = 0;
        mcnt = '{default: 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("mon_rst_resp_valid", 64'(resp_valid), 64'd0);
                chk("mon_rst_hits", hit_count, 64'd0);
                sb.delete();
                mptr = 0;
                mcnt = '{default: 0};
            end else begin
                ev = sb.size() != 0 && sb[0].due == cyc;
                chk("resp_valid", 64'(resp_valid), 64'(ev));
                for (int i = 0; i < NREQ; i++) begin
                    chk("hit_a", 64'(hit_count[16*i +: 16]), 64'(mcnt[i]));
                    chk("hit_b", 64'(hit_b[2*i +: 2]), 64'(mcnt[i] > 3 ? 3 : mcnt[i]));
                end
                if (ev) begin
                    e = sb.pop_front();
                    chk("resp_id", 64'(resp_id), 64'(e.id));
                    chk("resp_num", 64'(resp_num), 64'(e.num));
                    chk("resp_ispow3", 64'(resp_ispow3), 64'(e.pow3));
                end
                if (clr_counts) mcnt = '{default: 0};
                else if (ev && e.pow3) mcnt[e.id]++;
                eg = '0;
                for (int k = 0; k < NREQ; k++) begin
                    int j;
                    j = (mptr + k) % NREQ;
                    if (eg == '0 && req_valid[j]) begin
                        eg[j] = 1'b1;
                        gid = j;
                    end
                end
                chk("req_ready", 64'(req_ready), 64'(eg));
                if (eg != '0) begin
                    sb.push_back('{due: cyc + 1 + LAT, id: gid, num: req_num[32*gid +: 32],
                                   pow3: ref_pow3(req_num[32*gid +: 32])});
                    mptr = (gid + 1) % NREQ;
                end
            end
        end
    end

    // directed stimulus sequence
    initial begin
        logic [63:0] p;
        int n;
        #3;
        rst = 1'b1;
        #1;
        check_zero("init");
        @(posedge clk);
        #2;
        rst = 1'b0;

        // single request from requester 0
        pend[0].push_back(32'd27);
        drive();
        drain("t1");
        chk("t1_hit0", 64'(hit_count[15:0]), 64'd1);

        // all four at once from ptr 0
        do_reset();
        pend[0].push_back(32'd1);
        pend[1].push_back(32'd2);
        pend[2].push_back(32'd9);
        pend[3].push_back(32'd0);
        drive();
        #1;
        chk("t2_first_grant", 64'(req_ready), 64'b0001);
        drain("t2");
        chk("t2_hits", hit_count, 64'h0000_0001_0000_0001);

        // streaming powers of three from requester 2
        do_reset();
        p = 64'd1;
        for (int i = 0; i <= 20; i++) begin
            pend[2].push_back(p[31:0]);
            p = p * 3;
        end
        pend[2].push_back(32'd3486784402);
        drive();
        n = 0;
        while (pend[2].size() != 0 && n < 60) begin
            tick();
            n++;
        end
        chk("t3_accept_cycles", 64'(n), 64'd22);
        drain("t3");
        chk("t3_hit2", 64'(hit_count[47:32]), 64'd21);

        // saturation in the narrow instance, then clear coincident with a hit
        do_reset();
        pend[1] = '{32'd3, 32'd9, 32'd27, 32'd81, 32'd243};
        drive();
        drain("t4");
        chk("t4_hit1_wide", 64'(hit_count[31:16]), 64'd5);
        chk("t4_hit1_sat", 64'(hit_b[3:2]), 64'd3);
        pend[1].push_back(32'd3);
        drive();
        n = 0;
        while (!resp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("t4_resp_seen", 64'(resp_valid), 64'd1);
        clr_counts = 1'b1;
        tick();
        clr_counts = 1'b0;
        chk("t4_clr_wide", hit_count, 64'd0);
        chk("t4_clr_sat", 64'(hit_b), 64'd0);
        drain("t4c");

        // reset with operands in flight
        do_reset();
        pend[0].push_back(32'd81);
        pend[1].push_back(32'd243);
        drive();
        repeat (3) tick();
        chk("t5_pre_resp", 64'(resp_valid), 64'd1);
        rst = 1'b1;
        #1;
        check_zero("t5_mid");
        tick();
        rst = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < NREQ; i++) pend[i].push_back(32'd5 + i);
        drive();
        #1;
        chk("t5_grant_after_rst", 64'(req_ready), 64'b0001);
        drain("t5");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/powerof3_sched.md
# powerof3_sched

Round-robin scheduler that shares one `powerof3` checker between NREQ requesters. It accepts at most one 32-bit number per cycle and launches it into the checker. It tracks each in-flight number with a tag pipeline matched to the checker latency, then returns the result tagged with the requester ID. It also keeps per-requester saturating hit counters; the checker instance sits beside this block, driven by `chk_num`.

## Interface
- `NREQ`, default 4: number of requesters, 2..16.
- `LAT`, default 2: rising edges from a `chk_num` update to the edge at which the matching `chk_ispow3` is sampled. Two edges suits the registered-input/registered-output `powerof3`. Range ≥1.
- `CNTW`, default 16: hit counter width.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NREQ  request valid per requester.
- `req_num`  in  NREQ*32  request numbers, requester i at bits [32i+31:32i].
- `req_ready`  out  NREQ  one-hot grant; combinational from `req_valid` and the priority pointer.
- `chk_num`  out  32  registered operand to checker.
- `chk_ispow3`  in  1  checker result.
- `resp_valid`  out  1  response strobe, one cycle; no backpressure.
- `resp_id`  out  $clog2(NREQ)  requester of response.
- `resp_num`  out  32  number that was checked.
- `resp_ispow3`  out  1  result.
- `clr_counts`  in  1  synchronous clear of all hit counters.
- `hit_count`  out  NREQ*CNTW  per-requester count of ispow3=1 responses, requester i at bits [CNTW*i+CNTW-1:CNTW*i].

## Operation
- Arbitration:
  - Pointer `ptr` names the highest-priority requester.
  - `req_ready[i]` is 1 only for the first i with `req_valid[i]`=1, scanning ptr, ptr+1, … mod NREQ.
  - All zero when no valid.
- Handshake: transfer when `req_valid[i]&req_ready[i]`. Requester must hold `req_valid` and `req_num` stable until accepted.
- On an accept edge:
  - `chk_num` <= accepted number.
  - Tag stage 1 <= {1, id, num}.
  - `ptr` <= (id+1) mod NREQ.
- With no accept, `ptr` and `chk_num` hold, and tag stage 1 valid <= 0.
- The tag pipeline has LAT stages and shifts every cycle, with no stalls.
- When the last stage is valid at an edge, that edge registers:
  - `resp_valid`=1, `resp_id`/`resp_num` from the tag, `resp_ispow3`=`chk_ispow3`.
- Otherwise `resp_valid` <= 0, and `resp_id`/`resp_num`/`resp_ispow3` hold.
- Hit counters:
  - On an edge with `resp_valid`=1 and `resp_ispow3`=1, `hit_count[resp_id]` increments.
  - Counters saturate at all-ones and do not wrap.
  - `clr_counts`=1 zeroes all counters on that edge; clear wins over a coincident increment.
- Responses leave in acceptance order: one checker, fixed latency.

## Timing
- Throughput: one accept per cycle; back-to-back accepts from the same or different requesters are allowed.
- Latency: a number accepted at edge k appears on `resp_*` after edge k+LAT. With LAT=2, visible 2 cycles after accept.
- Fairness: with all NREQ valid continuously, grants rotate 0,1,…,NREQ-1,0,… and each requester waits at most NREQ-1 cycles.
- Reset, asynchronous, values immediately on `rst`=1:
  - `ptr`=0, `chk_num`=0, all tag valids 0.
  - `resp_valid`=0, `resp_id`=0, `resp_num`=0, `resp_ispow3`=0.
  - `hit_count`=0.
  - `req_ready` follows `req_valid` with ptr=0, but no accept occurs while `rst`=1.
- Reset mid-operation drops all in-flight tags. No response is emitted for them after reset release.
- `req_valid` deasserting before a grant is legal; no transfer occurs.
- The checker itself defines num=0 as not a power and num=1 (3^0) as a power; this block does no arithmetic on numbers.

## Structure
- `powerof3_pkg`:
  - `NUM_W`=32.
  - Typedef `p3_tag_t` {valid, id, num}; the id field is sized for the maximum NREQ=16.
  - Function returning next pointer mod NREQ.
- Sub-module `rr_arbiter`: parameter N; inputs `req[N]`, `ptr`; outputs one-hot `gnt[N]`, `gnt_id`. Purely combinational, reusable.
- Top `powerof3_sched` holds:
  - `ptr` register.
  - `chk_num` register.
  - LAT-deep `p3_tag_t` shift register.
  - Response registers.
  - NREQ saturating counters.
- The bench instantiates `powerof3` alongside and connects `chk_num`/`chk_ispow3`.

## Test plan
- Requester 0 sends 27, others idle, LAT=2 → accepted edge k; edge k+2: `resp_valid`=1, id 0, num 27, ispow3=1; `hit_count[0]`=1.
- All four valid at once, nums 1, 2, 9, 0, ptr=0 → grants 0,1,2,3 on consecutive cycles; responses in same order, ispow3 1,0,1,0; counts 1,0,1,0.
- Requester 2 streams 3^0…3^20 (3^20=3486784401), then 3486784402, every cycle → one accept per cycle; 21 ispow3=1 responses then one 0; `hit_count[2]`=21.
- CNTW=2, requester 1 sends 3, 9, 27, 81, 243 → `hit_count[1]` reads 1,2,3,3,3; then `clr_counts` coincident with a hit → 0.
- Accept 81 and 243, assert `rst` one cycle later for one cycle → all outputs zero immediately; no `resp_valid` afterward; next accept goes to requester 0 first when all valid (ptr=0).
